// File: rtl/dec_timer_reg_pkg.sv
// Shared types and defaults for the down-counting timer register.
package dec_timer_reg_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/dec_timer_reg.sv
// Loadable down-counter: manual load/decrement in IDLE, or timed countdown
// with a one-cycle done pulse on expiry and optional automatic reload.
module dec_timer_reg
    import dec_timer_reg_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             dec,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    timer_state_t     state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic [WIDTH-1:0] load_val;

    // Value the count takes this cycle if no arithmetic happens: ld wins over hold.
    assign load_val = ld ? in : out_reg;

    always_comb begin
        state_next  = state_reg;
        out_next    = out_reg;
        reload_next = reload_reg;

        if (stop) begin
            state_next = IDLE;
            out_next   = load_val;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        out_next    = load_val;
                        reload_next = load_val;
                        state_next  = (load_val != '0) ? RUN : DONE;
                    end else if (ld) begin
                        out_next = in;
                    end else if (dec) begin
                        out_next = out_reg - WIDTH'(1);
                    end
                end
                RUN: begin
                    if (ld) begin
                        out_next = in;
                    end else if (out_reg <= WIDTH'(1)) begin
                        // Expiry: clamp at zero so the count never wraps while running.
                        out_next   = '0;
                        state_next = DONE;
                    end else begin
                        out_next = out_reg - WIDTH'(1);
                    end
                end
                DONE: begin
                    if (AUTO_RELOAD) begin
                        out_next   = ld ? in : reload_reg;
                        state_next = (out_next != '0) ? RUN : DONE;
                    end else begin
                        out_next   = load_val;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            out_reg    <= '0;
            reload_reg <= '0;
        end else begin
            state_reg  <= state_next;
            out_reg    <= out_next;
            reload_reg <= reload_next;
        end
    end

    assign out  = out_reg;
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign zero = (out_reg == '0);

endmodule

// File: tb/tb_dec_timer_reg.sv
// Scoreboard bench: stimulus queues expected per-cycle results for the one-shot
// and auto-reload instances; a negedge monitor pops and compares them.
module tb_dec_timer_reg;

    logic       clk;
    logic       rst, ld, dec, start, stop;
    logic [7:0] in;
    logic [7:0] out0, out1;
    logic       busy0, busy1, zero0, zero1, done0, done1;

    int cyc;
    int checks;
    int errors;

    typedef struct {
        int         cyc;
        int         sel;
        string      name;
        logic [7:0] o;
        logic       b;
        logic       d;
    } exp_t;

    exp_t exp_q[$];

    dec_timer_reg #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ld(ld), .dec(dec), .start(start), .stop(stop),
        .in(in), .out(out0), .busy(busy0), .zero(zero0), .done(done0)
    );

    dec_timer_reg #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ld(ld), .dec(dec), .start(start), .stop(stop),
        .in(in), .out(out1), .busy(busy1), .zero(zero1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] ao;
            logic ab, ad, az, ez;
            e  = exp_q.pop_front();
            ao = (e.sel == 0) ? out0  : out1;
            ab = (e.sel == 0) ? busy0 : busy1;
            ad = (e.sel == 0) ? done0 : done1;
            az = (e.sel == 0) ? zero0 : zero1;
            ez = (e.o == 8'h00);
            checks++;
            if (ao !== e.o || ab !== e.b || ad !== e.d || az !== ez) begin
                errors++;
                $display("FAIL %s dut%0d: got out=%02h busy=%b done=%b zero=%b, want out=%02h busy=%b done=%b zero=%b",
                         e.name, e.sel, ao, ab, ad, az, e.o, e.b, e.d, ez);
            end else begin
                $display("ok   %s dut%0d: out=%02h busy=%b done=%b zero=%b",
                         e.name, e.sel, ao, ab, ad, az);
            end
        end
    end

    task automatic push(input string name, input int sel, input logic [7:0] o,
                        input logic b, input logic d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.sel  = sel;
        e.name = name;
        e.o    = o;
        e.b    = b;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic l, input logic dc, input logic st,
                        input logic sp, input logic [7:0] din);
        rst   = r;
        ld    = l;
        dec   = dc;
        start = st;
        stop  = sp;
        in    = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; ld = 1'b0; dec = 1'b0; start = 1'b0; stop = 1'b0; in = 8'h00;
        @(posedge clk);
        #1;

        // 1: reset overrides ld, then plain load
        push("rst_over_ld", 0, 8'h00, 1'b0, 1'b0);
        push("rst_over_ld", 1, 8'h00, 1'b0, 1'b0);
        step(1, 1, 0, 0, 0, 8'hAA);
        push("load_05", 0, 8'h05, 1'b0, 1'b0);
        step(0, 1, 0, 0, 0, 8'h05);

        // 2: decrement wraps, ld beats dec
        step(1, 0, 0, 0, 0, 8'h00);
        push("dec_wrap", 0, 8'hFF, 1'b0, 1'b0);
        step(0, 0, 1, 0, 0, 8'h00);
        push("ld_beats_dec", 0, 8'h10, 1'b0, 1'b0);
        step(0, 1, 1, 0, 0, 8'h10);

        // 3: one-shot countdown from 3; dec ignored while running
        push("ld_03", 0, 8'h03, 1'b0, 1'b0);
        step(0, 1, 0, 0, 0, 8'h03);
        push("start_3", 0, 8'h03, 1'b1, 1'b0);
        step(0, 0, 0, 1, 0, 8'h00);
        push("run_2_dec_ign", 0, 8'h02, 1'b1, 1'b0);
        step(0, 0, 1, 0, 0, 8'h00);
        push("run_1", 0, 8'h01, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        push("done_3rd", 0, 8'h00, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0, 8'h00);
        push("back_idle", 0, 8'h00, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);

        // 4: auto-reload period 2, then stop holds the count
        step(1, 0, 0, 0, 0, 8'h00);
        push("ar_ld_02", 1, 8'h02, 1'b0, 1'b0);
        step(0, 1, 0, 0, 0, 8'h02);
        push("ar_start", 1, 8'h02, 1'b1, 1'b0);
        step(0, 0, 0, 1, 0, 8'h00);
        push("ar_1", 1, 8'h01, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        push("ar_done_a", 1, 8'h00, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0, 8'h00);
        push("ar_reload", 1, 8'h02, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        push("ar_1b", 1, 8'h01, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        push("ar_done_b", 1, 8'h00, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0, 8'h00);
        push("ar_reload_b", 1, 8'h02, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        push("ar_stop", 1, 8'h02, 1'b0, 1'b0);
        step(0, 0, 0, 0, 1, 8'h00);
        push("ar_held", 1, 8'h02, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);

        // 5: ld during RUN to 1 and to 0
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h04);
        push("start_4", 0, 8'h04, 1'b1, 1'b0);
        step(0, 0, 0, 1, 0, 8'h00);
        push("run_ld_01", 0, 8'h01, 1'b1, 1'b0);
        step(0, 1, 0, 0, 0, 8'h01);
        push("run_ld1_done", 0, 8'h00, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0, 8'h00);
        push("run_ld1_idle", 0, 8'h00, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h05);
        push("start_5", 0, 8'h05, 1'b1, 1'b0);
        step(0, 0, 0, 1, 0, 8'h00);
        push("run_ld_00", 0, 8'h00, 1'b1, 1'b0);
        step(0, 1, 0, 0, 0, 8'h00);
        push("run_ld0_done", 0, 8'h00, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0, 8'h00);

        // 6: start at zero, then reset mid-run
        step(1, 0, 0, 0, 0, 8'h00);
        push("start_zero", 0, 8'h00, 1'b1, 1'b1);
        step(0, 0, 0, 1, 0, 8'h00);
        push("zero_idle", 0, 8'h00, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h07);
        push("start_7", 0, 8'h07, 1'b1, 1'b0);
        step(0, 0, 0, 1, 0, 8'h00);
        push("run_6", 0, 8'h06, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        push("rst_mid_run", 0, 8'h00, 1'b0, 1'b0);
        step(1, 0, 0, 0, 0, 8'h00);
        push("no_pulse_a", 0, 8'h00, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);
        push("no_pulse_b", 0, 8'h00, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 8'h00);

        step(0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
